line_window_2x2: RTL and testbench

Upstream stage of the 2x2 convolution block. It takes the raster-order 8-bit pixel stream (one pixel per valid cycle, no backpressure) and forms complete 2x2 neighbourhoods using one line buffer. It emits one window per valid position, so the convolution stage receives all four taps in a single cycle. Default frame size is 640x360, which is 230400 pixels.

---
 rtl/line_window_2x2.sv | 112 +++++++++++
 tb/tb_line_window_2x2.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/line_window_2x2.sv
// Forms 2x2 pixel neighbourhoods from a raster-order pixel stream using a single
// line buffer; one registered window per interior pixel, no backpressure.
module line_window_2x2 #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 360,
   parameter int PIX_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   input  logic [PIX_W-1:0]   pixel_i,
   output logic               valid_o,
   output logic [4*PIX_W-1:0] win_o,
   output logic               frame_done_o,
   output logic [1:0]         state_o
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ROW0   = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [CW-1:0]      col_q, col_d;
   logic [RW-1:0]      row_q, row_d;
   logic [1:0]         state_q, state_d;
   logic [PIX_W-1:0]   cur_prev_q, cur_prev_d;
   logic [PIX_W-1:0]   top_prev_q, top_prev_d;
   logic [4*PIX_W-1:0] win_q, win_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;

   // Line buffer is never cleared: row 0 of every frame rewrites it before use.
   logic [PIX_W-1:0]   lb_q [IMG_W];
   logic [PIX_W-1:0]   top_cur;
   logic               col_last, row_last;

   assign top_cur  = lb_q[col_q];
   assign col_last = (col_q == CW'(IMG_W - 1));
   assign row_last = (row_q == RW'(IMG_H - 1));

   always_comb begin
      col_d      = col_q;
      row_d      = row_q;
      cur_prev_d = cur_prev_q;
      top_prev_d = top_prev_q;
      win_d      = win_q;
      valid_d    = 1'b0;
      done_d     = 1'b0;
      if (valid_i) begin
         cur_prev_d = pixel_i;
         top_prev_d = top_cur;
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         if (row_q != '0 && col_q != '0) begin
            valid_d = 1'b1;
            win_d   = {top_prev_q, top_cur, cur_prev_q, pixel_i};
         end
         done_d = row_last && col_last;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (valid_i) state_d = S_ROW0;
         S_ROW0:   if (valid_i && col_last) state_d = S_STREAM;
         S_STREAM: if (valid_i && row_last && col_last) state_d = S_DONE;
         S_DONE:   state_d = valid_i ? S_ROW0 : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         col_q      <= '0;
         row_q      <= '0;
         state_q    <= S_IDLE;
         cur_prev_q <= '0;
         top_prev_q <= '0;
         win_q      <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         state_q    <= state_d;
         cur_prev_q <= cur_prev_d;
         top_prev_q <= top_prev_d;
         win_q      <= win_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
      end
   end

   // Read of top_cur above sees the old entry; the write lands at the edge.
   always_ff @(posedge clk_i) begin
      if (valid_i && !rst_i) lb_q[col_q] <= pixel_i;
   end

   assign valid_o      = valid_q;
   assign win_o        = win_q;
   assign frame_done_o = done_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_line_window_2x2.sv
// Directed bench for line_window_2x2 at 4x3: a golden frame-image model pushes
// expected windows; a negedge monitor pops and compares them.
module tb_line_window_2x2;

   localparam int W = 4;
   localparam int H = 3;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        valid_i = 1'b0;
   logic [7:0]  pixel_i = '0;
   logic        valid_o;
   logic [31:0] win_o;
   logic        frame_done_o;
   logic [1:0]  state_o;

   line_window_2x2 #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .pixel_i(pixel_i),
      .valid_o(valid_o), .win_o(win_o), .frame_done_o(frame_done_o), .state_o(state_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   bit armed = 0;
   logic last_vi = 1'b0;
   logic [32:0] exp_q [$];
   logic [31:0] obs_q [$];
   logic [1:0]  st_log [$];
   logic [7:0]  img [H][W];
   int m_r = 0, m_c = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Golden model: whole-frame image, window taken from rows r-1 and r.
   task automatic model_accept(input logic [7:0] p);
      img[m_r][m_c] = p;
      if (m_r > 0 && m_c > 0)
         exp_q.push_back({(m_r == H-1 && m_c == W-1), img[m_r-1][m_c-1], img[m_r-1][m_c],
                          img[m_r][m_c-1], p});
      if (m_c == W-1) begin
         m_c = 0;
         m_r = (m_r == H-1) ? 0 : m_r + 1;
      end else m_c++;
   endtask

   task automatic drive(input logic v, input logic [7:0] p);
      valid_i = v;
      pixel_i = p;
      if (v) model_accept(p);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom));
   endtask

   task automatic start_test();
      obs_q.delete();
      st_log.delete();
      st_log.push_back(state_o);
      done_cnt = 0;
   endtask

   always @(posedge clk) last_vi <= valid_i;

   always @(negedge clk) begin
      if (armed) begin
         if (st_log.size() != 0 && st_log[st_log.size()-1] != state_o) st_log.push_back(state_o);
         if (!last_vi) chk("no_win_after_gap", valid_o, 0);
         if (valid_o) begin
            if (exp_q.size() == 0) chk("unexpected_window", win_o, 64'hDEAD);
            else begin
               logic [32:0] e;
               e = exp_q.pop_front();
               chk("win", win_o, e[31:0]);
               chk("frame_done", frame_done_o, e[32]);
            end
            obs_q.push_back(win_o);
            if (frame_done_o) done_cnt++;
         end else chk("frame_done_idle", frame_done_o, 0);
      end
   end

   logic [1:0] exp_st [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

   initial begin
      // reset
      rst_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", valid_o, 0);
      chk("rst_win", win_o, 0);
      chk("rst_done", frame_done_o, 0);
      chk("rst_state", state_o, 0);
      rst_i = 1'b0;
      armed = 1;
      idle(2);

      // test 1: continuous raster frame
      start_test();
      for (int i = 0; i < W*H; i++) drive(1'b1, 8'(i));
      idle(3);
      chk("t1_count", obs_q.size(), 6);
      chk("t1_first", obs_q[0], 32'h00010405);
      chk("t1_last", obs_q[5], 32'h06070A0B);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_state_len", st_log.size(), 5);
      for (int i = 0; i < 5 && i < st_log.size(); i++) chk("t1_state_seq", st_log[i], exp_st[i]);
      chk("t1_drain", exp_q.size(), 0);

      // test 2: same frame with random gaps
      start_test();
      for (int i = 0; i < W*H; i++) begin
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 5));
         drive(1'b1, 8'(i));
      end
      idle(3);
      chk("t2_count", obs_q.size(), 6);
      chk("t2_first", obs_q[0], 32'h00010405);
      chk("t2_last", obs_q[5], 32'h06070A0B);
      chk("t2_done_cnt", done_cnt, 1);
      chk("t2_drain", exp_q.size(), 0);

      // test 3: two frames back-to-back
      start_test();
      for (int i = 0; i < W*H; i++) drive(1'b1, 8'(i));
      for (int i = 0; i < W*H; i++) drive(1'b1, 8'(i + 32'h20));
      idle(3);
      chk("t3_count", obs_q.size(), 12);
      if (obs_q.size() > 6) chk("t3_second_first", obs_q[6], 32'h20212425);
      chk("t3_done_cnt", done_cnt, 2);
      chk("t3_drain", exp_q.size(), 0);

      // test 4: reset after pixel 6, discarded pixel during reset, full restart
      for (int i = 0; i <= 6; i++) drive(1'b1, 8'(i + 8'h40));
      rst_i = 1'b1;
      valid_i = 1'b1;
      pixel_i = 8'hEE;
      @(posedge clk); #1;
      chk("t4_rst_valid", valid_o, 0);
      chk("t4_rst_state", state_o, 0);
      rst_i = 1'b0;
      m_r = 0;
      m_c = 0;
      chk("t4_pre_drain", exp_q.size(), 0);
      start_test();
      idle(1);
      for (int i = 0; i < W*H; i++) drive(1'b1, 8'(i*3 + 1));
      idle(3);
      chk("t4_count", obs_q.size(), 6);
      if (obs_q.size() > 0) chk("t4_first", obs_q[0], {8'd1, 8'd4, 8'd13, 8'd16});
      chk("t4_done_cnt", done_cnt, 1);
      chk("t4_drain", exp_q.size(), 0);

      // test 5: random pixel data with occasional gaps
      start_test();
      for (int i = 0; i < W*H; i++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         drive(1'b1, 8'($urandom));
      end
      idle(3);
      chk("t5_count", obs_q.size(), 6);
      chk("t5_done_cnt", done_cnt, 1);
      chk("t5_drain", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
